line_buffer_sequencer: RTL and testbench

Sequences a convolution pass over one feature-map tile. Issues column reads to the activation SRAM and drives the KER_SIZE-column line buffer controls (valid, row-done, flush). Emits one window-ready token per output pixel to the PE array through a valid/ready handshake. Sits between the tile scheduler (start/done) and the line buffer plus PE array.

---
 rtl/line_buffer_sequencer_if.sv | 36 +++
 rtl/line_buffer_sequencer.sv | 169 ++++++++++++++++
 tb/tb_line_buffer_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_buffer_sequencer_if.sv
// Sequencer-side bus: SRAM column read port, line buffer controls and the
// window token handshake towards the PE array.
interface line_buffer_sequencer_if #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  logic              sram_rd_en;
  logic [ADDR_W-1:0] sram_rd_addr;
  logic              sram_rd_valid;
  logic              lb_valid;
  logic              lb_row_done;
  logic              lb_flush;
  // Window handshake: a token transfers on a cycle where win_valid and
  // win_ready are both high; once raised, win_valid/win_row/win_col hold
  // stable until that transfer (only abort or reset may withdraw them).
  logic              win_valid;
  logic              win_ready;
  logic [ROW_W-1:0]  win_row;
  logic [COL_W-1:0]  win_col;

  modport master (
    output sram_rd_en, sram_rd_addr, lb_valid, lb_row_done, lb_flush,
           win_valid, win_row, win_col,
    input  sram_rd_valid, win_ready
  );

  modport slave (
    input  sram_rd_en, sram_rd_addr, lb_valid, lb_row_done, lb_flush,
           win_valid, win_row, win_col,
    output sram_rd_valid, win_ready
  );
endinterface

// File: rtl/line_buffer_sequencer.sv
// Convolution pass sequencer: SRAM column reads, line buffer strobes, window tokens.
// Optional backpressure stall counter enabled by macro LB_SEQ_PERF_CNT_EN.
module line_buffer_sequencer #(
  parameter int KER_SIZE = 3,
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8,
  parameter int ADDR_W   = $clog2(IMG_W * IMG_H)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [15:0] perf_stall_cnt,
  output logic [2:0]  dbg_state,
  line_buffer_sequencer_if.master bus
);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam logic [COL_W-1:0] C_FIRST = COL_W'(KER_SIZE - 1);
  localparam logic [COL_W-1:0] C_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] R_LAST  = ROW_W'(IMG_H - KER_SIZE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5,
    S_ABORT = 3'd6
  } state_t;

  state_t            state;
  logic [ROW_W-1:0]  r;
  logic [COL_W-1:0]  c;
  logic [ADDR_W-1:0] addr;
  logic              rd_pending;
  logic              rd_en;
  logic              row_done;
  logic              flush;
  logic              win_valid;
  logic [ROW_W-1:0]  win_row;
  logic [COL_W-1:0]  win_col;

  assign dbg_state        = state;
  assign bus.sram_rd_en   = rd_en;
  assign bus.sram_rd_addr = addr;
  assign bus.lb_row_done  = row_done;
  assign bus.lb_flush     = flush;
  assign bus.win_valid    = win_valid;
  assign bus.win_row      = win_row;
  assign bus.win_col      = win_col;
  // Column write strobe follows the returning data directly; abort wins.
  assign bus.lb_valid     = (state == S_WAIT) && bus.sram_rd_valid && !abort;

  // Raster address r*IMG_W+c only ever steps by one, so it is kept as a counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      r          <= '0;
      c          <= '0;
      addr       <= '0;
      rd_pending <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      row_done   <= 1'b0;
      flush      <= 1'b0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
    end else begin
      done     <= 1'b0;
      rd_en    <= 1'b0;
      row_done <= 1'b0;
      flush    <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state <= S_FLUSH;
          busy  <= 1'b1;
          flush <= 1'b1;
          r     <= '0;
          c     <= '0;
          addr  <= '0;
        end
        S_FLUSH: if (abort) state <= S_ABORT;
        else begin
          state <= S_REQ;
          rd_en <= 1'b1;
        end
        S_REQ: begin
          rd_pending <= 1'b1;
          state      <= abort ? S_ABORT : S_WAIT;
        end
        S_WAIT: begin
          if (bus.sram_rd_valid) rd_pending <= 1'b0;
          if (abort) state <= S_ABORT;
          else if (bus.sram_rd_valid) begin
            if (c >= C_FIRST) begin
              state     <= S_OUT;
              win_valid <= 1'b1;
              win_row   <= r;
              win_col   <= c - C_FIRST;
            end else begin
              c     <= c + 1'b1;
              addr  <= addr + 1'b1;
              state <= S_REQ;
              rd_en <= 1'b1;
            end
          end
        end
        S_OUT: if (abort) begin
          win_valid <= 1'b0;
          state     <= S_ABORT;
        end else if (bus.win_ready) begin
          win_valid <= 1'b0;
          addr      <= addr + 1'b1;
          if (c != C_LAST) begin
            c     <= c + 1'b1;
            state <= S_REQ;
            rd_en <= 1'b1;
          end else begin
            row_done <= 1'b1;
            c        <= '0;
            if (r == R_LAST) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              r     <= r + 1'b1;
              state <= S_REQ;
              rd_en <= 1'b1;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        // Drain the outstanding read silently, flush for one cycle, then idle.
        S_ABORT: begin
          if (bus.sram_rd_valid) rd_pending <= 1'b0;
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (!rd_pending || bus.sram_rd_valid) begin
            flush <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LB_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      perf_stall_cnt <= 16'd0;
    else if (state == S_IDLE && start)
      perf_stall_cnt <= 16'd0;
    else if (win_valid && !bus.win_ready && perf_stall_cnt != 16'hFFFF)
      perf_stall_cnt <= perf_stall_cnt + 16'd1;
  end
`else
  assign perf_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_line_buffer_sequencer.sv
// Bench for line_buffer_sequencer (3x3 kernel, 8x8 tile): directed passes with
// an expected-address/window scoreboard checked by a separate monitor.
module tb_line_buffer_sequencer;
  localparam int KER = 3;
  localparam int W   = 8;
  localparam int H   = 8;
  localparam int AW  = $clog2(W * H);
  localparam int RW  = $clog2(H);
  localparam int CW  = $clog2(W);
  localparam int WW  = RW + CW;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] perf;
  logic [2:0]  dbg_state;
  logic        model_valid = 1'b0;
  logic        extra_valid = 1'b0;
  logic        win_ready_tb = 1'b1;
  int          fix_lat = 2;
  bit          rand_lat = 1'b0;

  line_buffer_sequencer_if #(.IMG_W(W), .IMG_H(H)) bus ();
  assign bus.sram_rd_valid = model_valid | extra_valid;
  assign bus.win_ready     = win_ready_tb;

  line_buffer_sequencer #(.KER_SIZE(KER), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .busy(busy),
    .done(done), .perf_stall_cnt(perf), .dbg_state(dbg_state), .bus(bus)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard
  logic [AW-1:0] exp_addr_q[$];
  logic [WW-1:0] exp_q[$];
  int win_cycles[$];
  int n_rd = 0, n_lbv = 0, n_rowdone = 0, n_done = 0, n_flush = 0, n_win = 0;
  int last_ret = -1, last_flush = -1;

  task automatic push_pass();
    for (int r = 0; r <= H - KER; r++) begin
      for (int c = 0; c < W; c++) exp_addr_q.push_back(AW'(r * W + c));
      for (int c = 0; c <= W - KER; c++) exp_q.push_back({RW'(r), CW'(c)});
    end
  endtask

  // monitor
  initial begin
    logic [AW-1:0] ea;
    logic [WW-1:0] ew;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (bus.sram_rd_en) begin
          n_rd++;
          if (exp_addr_q.size() == 0) check("unexpected_read", 1, 0);
          else begin
            ea = exp_addr_q.pop_front();
            check("rd_addr", bus.sram_rd_addr, ea);
          end
        end
        if (bus.win_valid && bus.win_ready) begin
          n_win++;
          win_cycles.push_back(cyc);
          if (exp_q.size() == 0) check("unexpected_window", 1, 0);
          else begin
            ew = exp_q.pop_front();
            check("win_pos", {bus.win_row, bus.win_col}, ew);
          end
        end
        if (bus.lb_valid) n_lbv++;
        if (bus.lb_row_done) n_rowdone++;
        if (done) n_done++;
        if (bus.sram_rd_valid) last_ret = cyc;
        if (bus.lb_flush) begin
          n_flush++;
          last_flush = cyc;
        end
      end
    end
  end

  // SRAM model: one read in flight, data returns lat cycles after the request
  initial begin
    int lat;
    forever begin
      @(negedge clk);
      if (rstn && bus.sram_rd_en) begin
        lat = rand_lat ? $urandom_range(1, 6) : fix_lat;
        repeat (lat) @(posedge clk);
        #1 model_valid = 1'b1;
        @(posedge clk);
        #1 model_valid = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = n_done;
    for (int k = 0; k < budget && n_done == d0; k++) step(1);
    check("done_seen", int'(n_done != d0), 1);
  endtask

  task automatic wait_win(input int budget);
    for (int k = 0; k < budget && !bus.win_valid; k++) step(1);
    check("win_valid_seen", bus.win_valid, 1);
  endtask

  initial begin
    int rd0, lbv0, rdn0, dn0, fl0, win0;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, lbv0, rdn0, dn0, fl0, win0, exp_perf;
`ifdef LB_SEQ_PERF_CNT_EN
    exp_perf = 5;
`else
    exp_perf = 0;
`endif
    // reset state
    step(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", bus.sram_rd_en, 0);
    check("rst_addr", bus.sram_rd_addr, 0);
    check("rst_flush", bus.lb_flush, 0);
    check("rst_win_valid", bus.win_valid, 0);
    check("rst_state", dbg_state, 0);
    check("rst_perf", perf, 0);
    rstn = 1'b1;
    step(2);

    // full pass, latency 2, ready high, second start mid-pass ignored
    fix_lat = 2; rand_lat = 1'b0; win_ready_tb = 1'b1;
    win_cycles.delete();
    rd0 = n_rd; lbv0 = n_lbv; rdn0 = n_rowdone; dn0 = n_done; fl0 = n_flush; win0 = n_win;
    push_pass();
    pulse_start();
    check("busy_after_start", busy, 1);
    step(30);
    pulse_start();
    wait_done(1000);
    step(10);
    check("p1_reads", n_rd - rd0, 48);
    check("p1_lb_valid", n_lbv - lbv0, 48);
    check("p1_windows", n_win - win0, 36);
    check("p1_row_done", n_rowdone - rdn0, 6);
    check("p1_done", n_done - dn0, 1);
    check("p1_flush", n_flush - fl0, 1);
    check("p1_busy_end", busy, 0);
    check("p1_win_interval", win_cycles[1] - win_cycles[0], 4);
    check("p1_addr_q_empty", exp_addr_q.size(), 0);
    check("p1_win_q_empty", exp_q.size(), 0);

    // backpressure on the first window for 5 cycles
    win_ready_tb = 1'b0;
    push_pass();
    dn0 = n_done;
    pulse_start();
    wait_win(50);
    rd0 = n_rd;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", bus.win_valid, 1);
      check("stall_row", bus.win_row, 0);
      check("stall_col", bus.win_col, 0);
      step(1);
    end
    check("stall_no_read", n_rd - rd0, 0);
    win_ready_tb = 1'b1;
    wait_done(1000);
    step(5);
    check("stall_perf", perf, exp_perf);
    check("stall_done", n_done - dn0, 1);
    check("stall_win_q_empty", exp_q.size(), 0);

    // abort in WAIT with the read returning 3 cycles later
    fix_lat = 5;
    exp_addr_q.push_back(AW'(0));
    lbv0 = n_lbv; fl0 = n_flush; dn0 = n_done; rdn0 = n_rowdone;
    pulse_start();
    for (int k = 0; k < 20 && !bus.sram_rd_en; k++) step(1);
    step(1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_state", dbg_state, 6);
    check("abort_win_valid", bus.win_valid, 0);
    step(15);
    check("abort_no_lb_valid", n_lbv - lbv0, 0);
    check("abort_flush_count", n_flush - fl0, 2);
    check("abort_flush_after_ret", last_flush - last_ret, 1);
    check("abort_no_done", n_done - dn0, 0);
    check("abort_no_row_done", n_rowdone - rdn0, 0);
    check("abort_idle", dbg_state, 0);
    check("abort_busy", busy, 0);

    // random latency pass restarting from address 0
    rand_lat = 1'b1;
    push_pass();
    rd0 = n_rd; lbv0 = n_lbv; dn0 = n_done; win0 = n_win;
    pulse_start();
    wait_done(2000);
    step(10);
    check("rand_reads", n_rd - rd0, 48);
    check("rand_lb_valid", n_lbv - lbv0, 48);
    check("rand_windows", n_win - win0, 36);
    check("rand_done", n_done - dn0, 1);
    check("rand_q_empty", exp_q.size() + exp_addr_q.size(), 0);

    // asynchronous reset while in OUT, then a stray read return
    rand_lat = 1'b0; fix_lat = 2; win_ready_tb = 1'b0;
    for (int a = 0; a < KER; a++) exp_addr_q.push_back(AW'(a));
    pulse_start();
    wait_win(50);
    #2 rstn = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_win_valid", bus.win_valid, 0);
    check("arst_addr", bus.sram_rd_addr, 0);
    check("arst_state", dbg_state, 0);
    check("arst_perf", perf, 0);
    step(2);
    rstn = 1'b1;
    win_ready_tb = 1'b1;
    lbv0 = n_lbv;
    step(1);
    extra_valid = 1'b1;
    check("late_lb_valid", bus.lb_valid, 0);
    step(1);
    extra_valid = 1'b0;
    step(3);
    check("late_lb_count", n_lbv - lbv0, 0);
    check("late_idle", dbg_state, 0);
    check("late_addr_q_empty", exp_addr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
